i_mem_access_ctrl: RTL
======================

Name: i_mem_access_ctrl

Overview:
Controller placed between the core fetch unit, the fabric interface and the dual-port instruction memory. It shares memory port A (read/write) between core fetch reads and fabric writes. It routes fabric reads to memory port B, which is read-only. It also supports a fabric "lock" mode for bulk program loading while core fetch is held off.

Parameters:
ADDR_W, 14, word-address width (equals MSB_I_MEM-1 from mini_core_pkg).
STARVE_MAX, 4, number of consecutive cycles a pending fabric write may lose to the core before it is forced through.

Ports:
clock  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
core_rd_req  in  1  core fetch request
core_addr  in  ADDR_W  core word address
core_stall  out  1  fetch not accepted this cycle
core_rvalid  out  1  core_rdata valid
core_rdata  out  32  fetched instruction
fab_req  in  1  fabric request, held until fab_ack
fab_wr  in  1  1=write, 0=read
fab_addr  in  ADDR_W  fabric word address
fab_wdata  in  32  fabric write data
fab_ack  out  1  one-cycle request acceptance
fab_rvalid  out  1  fab_rdata valid
fab_rdata  out  32  fabric read data
fab_lock  in  1  request exclusive port-A ownership for loading
fab_locked  out  1  lock granted
mem_address_a  out  ADDR_W  to memory port A
mem_data_a  out  32  to memory port A
mem_rden_a  out  1  to memory port A
mem_wren_a  out  1  to memory port A
mem_q_a  in  32  memory port A read data, registered, valid 1 cycle after rden
mem_address_b  out  ADDR_W  to memory port B
mem_rden_b  out  1  to memory port B
mem_q_b  in  32  memory port B read data, valid 1 cycle after rden

Behaviour:
- Reset: all outputs 0; FSM=RUN; starvation counter=0; read-tracking flags cleared.
- Memory latency is fixed at 1 cycle; rvalid is a registered copy of the issued rden.
- Fabric reads (fab_req & !fab_wr): issued on port B in the same cycle as the request, regardless of FSM state.
  - fab_ack is asserted combinationally that cycle.
  - fab_rvalid=1 and fab_rdata=mem_q_b on the next cycle.
- Fabric writes in RUN:
  - If core_rd_req=0, or the starvation counter==STARVE_MAX: write is granted. mem_wren_a=1, fab_ack=1, counter clears. If core_rd_req=1 in that cycle, core_stall=1 and no core read is issued.
  - Otherwise the core wins and the counter increments, saturating at STARVE_MAX.
  - The counter clears whenever no fabric write is pending.
- Core reads in RUN when not stalled: mem_rden_a=1, mem_address_a=core_addr. core_rvalid=1 and core_rdata=mem_q_a on the next cycle.
- Read-after-write ordering: a core read issued in the cycle after a fabric write to the same address returns the new data. No bypass is needed.
- FSM:
  - RUN: fab_lock=1 and a core read is in flight → DRAIN. fab_lock=1 and no core read in flight → LOCKED.
  - DRAIN: core_stall=1 and no new core reads are issued. Fabric writes are granted immediately. When the in-flight core_rvalid completes → LOCKED.
  - LOCKED: fab_locked=1, core_stall=1 continuously. Fabric writes are granted every cycle they are requested. fab_lock=0 → RUN the next cycle, with fab_locked=0 in that cycle.
- Simultaneous fab_lock rise and a pending fabric write: the write is granted first (same cycle), and the lock transition happens in parallel.
- Reset mid-operation: in-flight rvalid is dropped (0 the next cycle), FSM→RUN, lock is released.
- mem_data_a=fab_wdata always. mem_rden_a and mem_wren_a are never both 1.

Optional Feature:
I_MEM_WR_PROTECT_EN
- When defined, an extra port is added: fab_err out 1.
- Fabric writes in RUN or DRAIN with fab_addr below the parameter PROT_LIMIT (default 256) are acknowledged but not written. mem_wren_a=0 and fab_err=1 for that cycle.
- In LOCKED, all writes are allowed.
- When not defined, no protection logic and no fab_err port.

Test Plan:
- Core streams reads at 0x0..0x7, memory preloaded with value=addr → core_rvalid every cycle, one cycle after each request, with core_rdata=0x0..0x7; core_stall never asserted.
- Core reading continuously plus a fabric write to 0x10 of 0xDEADBEEF held from cycle 0, STARVE_MAX=4 → write granted on cycle 4; core_stall=1 only that cycle; a later core read of 0x10 returns 0xDEADBEEF.
- Fabric read of 0x3 concurrent with a core read of 0x5 → fab_ack the same cycle; both rvalids next cycle with correct data, no stall.
- fab_lock asserted while a core read is in flight → DRAIN for 1 cycle, then fab_locked=1; 8 back-to-back fabric writes each acked in one cycle; fab_lock deasserted → core fetch resumes next cycle.
- rst asserted in the cycle after a core read issues → core_rvalid=0 next cycle; FSM in RUN; all outputs 0.
- With I_MEM_WR_PROTECT_EN: write to 0x20 in RUN → fab_err=1 and memory unchanged; the same write in LOCKED → written, fab_err=0.

Source files
------------

// File: rtl/i_mem_access_ctrl_if.sv
// Bus bundle between the instruction-memory access controller and its neighbours:
// the core fetch unit, the fabric, and the dual-port memory. The controller uses slave.
interface i_mem_access_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              core_rd_req;
    logic [ADDR_W-1:0] core_addr;
    logic              core_stall;
    logic              core_rvalid;
    logic [31:0]       core_rdata;

    logic              fab_req;
    logic              fab_wr;
    logic [ADDR_W-1:0] fab_addr;
    logic [31:0]       fab_wdata;
    logic              fab_ack;
    logic              fab_rvalid;
    logic [31:0]       fab_rdata;
    logic              fab_lock;
    logic              fab_locked;
`ifdef I_MEM_WR_PROTECT_EN
    logic              fab_err;
`endif

    logic [ADDR_W-1:0] mem_address_a;
    logic [31:0]       mem_data_a;
    logic              mem_rden_a;
    logic              mem_wren_a;
    logic [31:0]       mem_q_a;
    logic [ADDR_W-1:0] mem_address_b;
    logic              mem_rden_b;
    logic [31:0]       mem_q_b;

    modport slave (
`ifdef I_MEM_WR_PROTECT_EN
        output fab_err,
`endif
        input  core_rd_req, core_addr,
        input  fab_req, fab_wr, fab_addr, fab_wdata, fab_lock,
        input  mem_q_a, mem_q_b,
        output core_stall, core_rvalid, core_rdata,
        output fab_ack, fab_rvalid, fab_rdata, fab_locked,
        output mem_address_a, mem_data_a, mem_rden_a, mem_wren_a,
        output mem_address_b, mem_rden_b
    );

    modport master (
`ifdef I_MEM_WR_PROTECT_EN
        input  fab_err,
`endif
        output core_rd_req, core_addr,
        output fab_req, fab_wr, fab_addr, fab_wdata, fab_lock,
        output mem_q_a, mem_q_b,
        input  core_stall, core_rvalid, core_rdata,
        input  fab_ack, fab_rvalid, fab_rdata, fab_locked,
        input  mem_address_a, mem_data_a, mem_rden_a, mem_wren_a,
        input  mem_address_b, mem_rden_b
    );
endinterface

// File: rtl/i_mem_access_ctrl.sv
// Shares instruction-memory port A between core fetch and fabric writes (with starvation
// guard), sends fabric reads to port B, and offers a fabric lock for bulk program loading.
// Optional low-region write protection is enabled by defining I_MEM_WR_PROTECT_EN.
module i_mem_access_ctrl #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 4
`ifdef I_MEM_WR_PROTECT_EN
    ,
    parameter int PROT_LIMIT = 256
`endif
) (
    input logic                clock,
    input logic                rst,
    i_mem_access_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 2);

    // state     | meaning
    // ST_RUN    | core fetch and fabric share port A, starvation-guarded arbitration
    // ST_DRAIN  | lock requested, core held off while its last read returns
    // ST_LOCKED | fabric owns port A, every requested write goes through
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOCKED} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              core_rvalid_q, core_rvalid_d;
    logic              fab_rvalid_q, fab_rvalid_d;

    logic              wr_pend;
    logic              fab_rd;
    logic              grant;
    logic              core_issue;
    logic              stall;
    logic              wr_err;
    logic              wr_en;

    always_comb begin
        wr_pend    = bus.fab_req & bus.fab_wr;
        fab_rd     = bus.fab_req & ~bus.fab_wr;
        state_d    = state_q;
        cnt_d      = '0;
        grant      = 1'b0;
        core_issue = 1'b0;
        stall      = 1'b0;

        case (state_q)
            ST_RUN: begin
                // A lock request lets a pending write through first, in parallel with the transition.
                grant      = wr_pend & (~bus.core_rd_req | (cnt_q == CNT_W'(STARVE_MAX)) | bus.fab_lock);
                core_issue = bus.core_rd_req & ~grant;
                stall      = bus.core_rd_req & grant;
                if (wr_pend && !grant) begin
                    cnt_d = (cnt_q == CNT_W'(STARVE_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
                end
                if (bus.fab_lock) begin
                    state_d = core_issue ? ST_DRAIN : ST_LOCKED;
                end
            end
            ST_DRAIN: begin
                grant = wr_pend;
                stall = 1'b1;
                if (core_rvalid_q) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                grant = wr_pend;
                stall = 1'b1;
                if (!bus.fab_lock) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

`ifdef I_MEM_WR_PROTECT_EN
        wr_err = grant & (state_q != ST_LOCKED) & (int'(bus.fab_addr) < PROT_LIMIT);
`else
        wr_err = 1'b0;
`endif
        wr_en         = grant & ~wr_err;
        core_rvalid_d = core_issue;
        fab_rvalid_d  = fab_rd;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            core_rvalid_q <= 1'b0;
            fab_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            core_rvalid_q <= core_rvalid_d;
            fab_rvalid_q  <= fab_rvalid_d;
        end
    end

    // Every output is forced low while reset is held, including the registered read-valids.
    assign bus.core_stall    = ~rst & stall;
    assign bus.core_rvalid   = ~rst & core_rvalid_q;
    assign bus.core_rdata    = (~rst & core_rvalid_q) ? bus.mem_q_a : 32'd0;
    assign bus.fab_ack       = ~rst & (fab_rd | grant);
    assign bus.fab_rvalid    = ~rst & fab_rvalid_q;
    assign bus.fab_rdata     = (~rst & fab_rvalid_q) ? bus.mem_q_b : 32'd0;
    assign bus.fab_locked    = ~rst & (state_q == ST_LOCKED);
`ifdef I_MEM_WR_PROTECT_EN
    assign bus.fab_err       = ~rst & wr_err;
`endif

    assign bus.mem_rden_a    = ~rst & core_issue;
    assign bus.mem_wren_a    = ~rst & wr_en;
    assign bus.mem_address_a = rst        ? '0 :
                               wr_en      ? bus.fab_addr :
                               core_issue ? bus.core_addr : '0;
    assign bus.mem_data_a    = rst ? 32'd0 : bus.fab_wdata;
    assign bus.mem_rden_b    = ~rst & fab_rd;
    assign bus.mem_address_b = (~rst & fab_rd) ? bus.fab_addr : '0;

endmodule
